// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-unit defaults and fetch FSM state encoding.
package cpu_pkg;
  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 16;
  typedef enum logic [1:0] {PRIME, EMPTY, VALID, STALE} fetch_state_t;
endpackage

// File: rtl/instr_mem.sv
// instr_mem: 2^ADDR_W x DATA_W instruction memory, sync write, sync write-first read.
module instr_mem
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, prefetched instruction memory read and IR with validity tracking.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PC_clr,
  input  logic              PC_up,
  input  logic              IR_Id,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] IR,
  output logic [ADDR_W-1:0] PC,
  output logic              IR_valid,
  output logic              fetch_ready,
  output logic [15:0]       fetch_count
);
  fetch_state_t      state;
  logic [ADDR_W-1:0] pc_next, ir_addr;
  logic [DATA_W-1:0] prefetch;
  logic              accept;
  assign pc_next     = PC_clr ? '0 : PC_up ? PC + 1'b1 : PC;
  assign accept      = IR_Id && state != PRIME && !PC_clr;
  assign fetch_ready = state != PRIME;
  assign IR_valid    = state == VALID;
  // Reading at pc_next keeps prefetch equal to mem[PC] right after every edge.
  instr_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
    .clk(clk),
    .we(prog_we),
    .waddr(prog_addr),
    .wdata(prog_data),
    .raddr(pc_next),
    .rdata(prefetch)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC          <= '0;
      IR          <= '0;
      ir_addr     <= '0;
      fetch_count <= '0;
      state       <= PRIME;
    end else begin
      PC <= pc_next;
      if (accept) begin
        IR      <= prefetch;
        ir_addr <= PC;
        if (fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
      end
      state <= (state == PRIME || PC_clr) ? EMPTY :
               accept ? VALID :
               (state == VALID && prog_we && prog_addr == ir_addr) ? STALE : state;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed vector table, corner sequences and random run vs a reference model.
module tb_instr_fetch_unit;
  logic        clk = 0, rst = 1, PC_clr = 0, PC_up = 0, IR_Id = 0, prog_we = 0;
  logic [6:0]  prog_addr = 0, PC;
  logic [15:0] prog_data = 0, IR, fetch_count;
  logic        IR_valid, fetch_ready;
  int          checks = 0, errors = 0;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .PC_clr(PC_clr), .PC_up(PC_up), .IR_Id(IR_Id),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .IR(IR), .PC(PC), .IR_valid(IR_valid), .fetch_ready(fetch_ready),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Reference model: memory array plus the architectural registers.
  logic [15:0] m_mem [128];
  logic [15:0] m_ir;
  int          m_pc, m_ir_addr, m_cnt;
  bit          m_primed, m_valid;

  task automatic model_step();
    if (rst) begin
      m_pc = 0; m_ir = 0; m_ir_addr = 0; m_cnt = 0; m_primed = 0; m_valid = 0;
    end else begin
      if (m_primed && PC_clr) m_valid = 0;
      else if (m_primed && IR_Id) begin
        m_ir = m_mem[m_pc]; m_ir_addr = m_pc; m_valid = 1;
        if (m_cnt < 65535) m_cnt++;
      end else if (m_primed && prog_we && int'(prog_addr) == m_ir_addr) m_valid = 0;
      m_primed = 1;
      m_pc = PC_clr ? 0 : PC_up ? (m_pc + 1) % 128 : m_pc;
    end
    if (prog_we) m_mem[prog_addr] = prog_data;
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  task automatic chk_model(input string n);
    chk({n, "_pc"}, 32'(PC), 32'(m_pc));
    chk({n, "_ir"}, 32'(IR), 32'(m_ir));
    chk({n, "_valid"}, 32'(IR_valid), 32'(m_valid));
    chk({n, "_ready"}, 32'(fetch_ready), 32'(m_primed));
    chk({n, "_count"}, 32'(fetch_count), 32'(m_cnt));
  endtask

  task automatic cycle(input bit c, u, i, w, input logic [6:0] a, input logic [15:0] d);
    PC_clr = c; PC_up = u; IR_Id = i; prog_we = w; prog_addr = a; prog_data = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  typedef struct {
    bit c, u, i, w;
    logic [6:0] a;
    logic [15:0] d;
    int pc;
    logic [15:0] ir;
    bit v;
    int cnt;
  } vec_t;
  vec_t tbl[22];

  function automatic vec_t mk(bit c, u, i, w, logic [6:0] a, logic [15:0] d,
                              int pc, logic [15:0] ir, bit v, int cnt);
    mk = '{c, u, i, w, a, d, pc, ir, v, cnt};
  endfunction

  initial begin
    tbl[0]  = mk(0, 0, 0, 0, 0, 0,       0, 16'h0000, 0, 0);
    tbl[1]  = mk(0, 1, 1, 0, 0, 0,       1, 16'h3001, 1, 1);
    tbl[2]  = mk(0, 0, 1, 0, 0, 0,       1, 16'h4001, 1, 2);
    tbl[3]  = mk(1, 1, 1, 0, 0, 0,       0, 16'h4001, 0, 2);
    for (int k = 0; k < 5; k++) tbl[4 + k] = mk(0, 1, 0, 0, 0, 0, k + 1, 16'h4001, 0, 2);
    tbl[9]  = mk(0, 0, 1, 0, 0, 0,       5, 16'h1234, 1, 3);
    tbl[10] = mk(0, 0, 0, 1, 5, 16'h5000, 5, 16'h1234, 0, 3);
    tbl[11] = mk(1, 0, 0, 0, 0, 0,       0, 16'h1234, 0, 3);
    for (int k = 0; k < 5; k++) tbl[12 + k] = mk(0, 1, 0, 0, 0, 0, k + 1, 16'h1234, 0, 3);
    tbl[17] = mk(0, 0, 1, 0, 0, 0,       5, 16'h5000, 1, 4);
    tbl[18] = mk(0, 1, 0, 1, 6, 16'h6666, 6, 16'h5000, 1, 4);
    tbl[19] = mk(0, 0, 1, 0, 0, 0,       6, 16'h6666, 1, 5);
    tbl[20] = mk(0, 0, 1, 1, 6, 16'h7777, 6, 16'h6666, 1, 6);
    tbl[21] = mk(0, 0, 1, 0, 0, 0,       6, 16'h7777, 1, 7);

    rst = 1;
    @(negedge clk);
    for (int a = 0; a < 128; a++)
      cycle(0, 0, 0, 1, 7'(a), a == 0 ? 16'h3001 : a == 1 ? 16'h4001 : a == 5 ? 16'h1234 : 16'($urandom));
    cycle(0, 0, 0, 0, 0, 0);
    chk_model("reset");
    chk("reset_ir", 32'(IR), 0);
    rst = 0;
    chk("prime_ready", 32'(fetch_ready), 0);

    for (int k = 0; k < 22; k++) begin
      cycle(tbl[k].c, tbl[k].u, tbl[k].i, tbl[k].w, tbl[k].a, tbl[k].d);
      chk($sformatf("row%0d_pc", k), 32'(PC), 32'(tbl[k].pc));
      chk($sformatf("row%0d_ir", k), 32'(IR), 32'(tbl[k].ir));
      chk($sformatf("row%0d_valid", k), 32'(IR_valid), 32'(tbl[k].v));
      chk($sformatf("row%0d_ready", k), 32'(fetch_ready), 1);
      chk($sformatf("row%0d_count", k), 32'(fetch_count), 32'(tbl[k].cnt));
    end

    cycle(1, 0, 0, 0, 0, 0);
    repeat (127) cycle(0, 1, 0, 0, 0, 0);
    chk("pc_at_127", 32'(PC), 127);
    cycle(0, 1, 0, 0, 0, 0);
    chk("pc_wrap", 32'(PC), 0);
    cycle(0, 0, 1, 0, 0, 0);
    chk("wrap_ir", 32'(IR), 32'h3001);
    chk_model("wrap");

    for (int n = 0; n < 400; n++) begin
      int sel;
      logic [6:0] a;
      sel = int'($urandom_range(0, 2));
      a = sel == 0 ? 7'(m_pc + int'($urandom_range(0, 1))) : sel == 1 ? 7'(m_ir_addr) : 7'($urandom);
      cycle($urandom_range(0, 15) == 0, 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0,
            a, 16'($urandom));
      chk_model("rand");
    end

    rst = 1;
    cycle(0, 0, 0, 0, 0, 0);
    chk_model("rst2");
    rst = 0;
    chk("prime2_ready", 32'(fetch_ready), 0);
    cycle(0, 0, 1, 0, 0, 0);
    chk("prime_id_ir", 32'(IR), 0);
    chk("prime_id_count", 32'(fetch_count), 0);
    cycle(0, 1, 1, 0, 0, 0);
    chk("post_prime_count", 32'(fetch_count), 1);
    chk_model("post_prime");

    PC_up = 1; IR_Id = 1;
    #2 rst = 1;
    #1;
    chk("async_ir", 32'(IR), 0);
    chk("async_count", 32'(fetch_count), 0);
    chk("async_ready", 32'(fetch_ready), 0);
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk_model("async");
    rst = 0; PC_up = 0; IR_Id = 0;
    cycle(0, 0, 0, 0, 0, 0);
    chk_model("async_release");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, instruction memory address width (128 words).
REQ-002 SHALL have parameter DATA_W, default 16, instruction width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port PC_clr  input  1  clear PC to 0.
REQ-006 SHALL have port PC_up  input  1  increment PC.
REQ-007 SHALL have port IR_Id  input  1  load IR with instruction at current PC.
REQ-008 SHALL have port prog_we  input  1  program-load write strobe.
REQ-009 SHALL have port prog_addr  input  ADDR_W  program-load word address.
REQ-010 SHALL have port prog_data  input  DATA_W  program-load word.
REQ-011 SHALL have port IR  output  DATA_W  instruction register.
REQ-012 SHALL have port PC  output  ADDR_W  program counter.
REQ-013 SHALL have port IR_valid  output  1  IR holds a current, unmodified instruction.
REQ-014 SHALL have port fetch_ready  output  1  unit can accept IR_Id this cycle.
REQ-015 SHALL have port fetch_count  output  16  number of accepted fetches, saturating.

Function
REQ-016 SHALL update PC: PC_clr -> 0 (priority); else PC_up -> PC+1 modulo 2^ADDR_W (127 -> 0); else hold.
REQ-017 SHALL compute PC_next combinationally per REQ-016 and present it as the instruction memory read address.
REQ-018 SHALL register memory read data (prefetch register) every cycle, so that prefetch register == mem[PC] in the cycle after any PC update.
REQ-019 SHALL bypass on write-to-read collision: prog_we with prog_addr == PC_next loads prog_data into the prefetch register (write-first).
REQ-020 SHALL, on accepted IR_Id, load IR from the prefetch register at the same edge on which PC increments, so IR is valid in the cycle after IR_Id (1-cycle latency).
REQ-021 SHALL record IR_addr = PC at each accepted IR_Id.
REQ-022 SHALL implement FSM states PRIME, EMPTY, VALID, STALE.
REQ-023 SHALL transition PRIME -> EMPTY unconditionally after one cycle; PRIME fills the prefetch register with mem[0].
REQ-024 SHALL transition EMPTY/VALID/STALE -> VALID on accepted IR_Id.
REQ-025 SHALL transition VALID -> STALE on prog_we with prog_addr == IR_addr and no IR_Id in that cycle.
REQ-026 SHALL transition any state except PRIME -> EMPTY on PC_clr; IR holds its value and any IR_Id in that cycle is ignored.
REQ-027 SHALL drive fetch_ready = (state != PRIME), and IR_valid = (state == VALID).
REQ-028 SHALL ignore IR_Id during PRIME: IR unchanged, fetch_count unchanged; PC_clr/PC_up still act on PC.
REQ-029 SHALL increment fetch_count on each accepted IR_Id and hold it at 16'hFFFF.
REQ-030 SHALL accept prog_we in every state, including PRIME; memory contents are not affected by reset.

Reset
REQ-031 SHALL on rst force PC=0, IR=0, IR_addr=0, fetch_count=0, state=PRIME, and therefore IR_valid=0 and fetch_ready=0, asynchronously.
REQ-032 SHALL, when rst is asserted mid-fetch, discard the fetch: IR=0 and fetch_count not incremented.

Structure
REQ-033 SHALL place fetch FSM state enum and ADDR_W/DATA_W defaults in shared package cpu_pkg.
REQ-034 SHALL instantiate one sub-module instr_mem: 2^ADDR_W x DATA_W, one synchronous write port and one synchronous read port, no reset.

Verification
REQ-035 SHALL cover: preload mem[0]=16'h3001, mem[1]=16'h4001; rst; 1 idle cycle; IR_Id+PC_up -> next cycle IR=16'h3001, PC=1, IR_valid=1, fetch_count=1.
REQ-036 SHALL cover: PC=127 with PC_up -> PC=0; then IR_Id -> IR=mem[0].
REQ-037 SHALL cover: PC_clr+PC_up+IR_Id in same cycle -> PC=0, IR unchanged, IR_valid=0, fetch_count unchanged.
REQ-038 SHALL cover: IR loaded from addr 5, then prog_we addr 5 data 16'h5000 -> IR_valid=0 (STALE); subsequent IR_Id at PC=5 (after PC_clr + 5 PC_up) -> IR=16'h5000.
REQ-039 SHALL cover: prog_we to addr == PC_next with PC_up and then IR_Id next cycle -> IR=prog_data (bypass).
REQ-040 SHALL cover: IR_Id in the first cycle after rst release -> ignored (fetch_ready=0, IR=0), then accepted in the following cycle.
